// File: rtl/div_flag_enumerator_pkg.sv
// Shared definitions for the divisibility-flag enumerator: FSM state encoding
// and the default operand width.
package div_flag_enumerator_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_flag_enumerator_flags.sv
// Combinational value -> {even, div3} classifier; zero maps to {0,0}.
// Same function as the LED encoder, so the enumerator and its checkers agree.
module div_flags #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value_i,
  output logic             even_o,
  output logic             div3_o
);

  logic nonzero;

  assign nonzero = (value_i != '0);
  assign even_o  = nonzero && !value_i[0];
  assign div3_o  = nonzero && ((value_i % WIDTH'(3)) == '0);

endmodule

// File: rtl/div_flag_enumerator.sv
// Scans candidates 1 .. 2**WIDTH-1 and streams those whose {even, div3} flags
// equal the latched request over valid/ready, then pulses done for one cycle.
module div_flag_enumerator
  import div_flag_enumerator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             want_even,
  input  logic             want_div3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   match_cnt
);

  localparam logic [WIDTH-1:0] CAND_LAST = '1;
  localparam logic [WIDTH-1:0] CAND_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   CNT_ONE   = (WIDTH + 1)'(1);

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] cand_q,      cand_d;
  logic             want_even_q, want_even_d;
  logic             want_div3_q, want_div3_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic [WIDTH:0]   match_cnt_q, match_cnt_d;

  logic cand_even;
  logic cand_div3;
  logic cand_match;

  div_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .value_i (cand_q),
    .even_o  (cand_even),
    .div3_o  (cand_div3)
  );

  assign cand_match = (cand_even == want_even_q) && (cand_div3 == want_div3_q);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    want_even_d = want_even_q;
    want_div3_d = want_div3_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    match_cnt_d = match_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          want_even_d = want_even;
          want_div3_d = want_div3;
          cand_d      = CAND_ONE;
          match_cnt_d = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cand_match) begin
          out_value_d = cand_q;
          out_valid_d = 1'b1;
          match_cnt_d = match_cnt_q + CNT_ONE;
          state_d     = ST_EMIT;
        end else if (cand_q == CAND_LAST) begin
          state_d = ST_DONE;
        end else begin
          cand_d = cand_q + CAND_ONE;
        end
      end
      ST_EMIT: begin
        // The last candidate exits straight to DONE so cand never wraps to zero.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cand_q == CAND_LAST) begin
            state_d = ST_DONE;
          end else begin
            cand_d  = cand_q + CAND_ONE;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      want_even_q <= 1'b0;
      want_div3_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      want_even_q <= want_even_d;
      want_div3_q <= want_div3_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Status outputs decode the state register only, so no input reaches them combinationally.
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_EMIT);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_div_flag_enumerator.sv
// Directed + randomized bench for div_flag_enumerator against an arithmetic
// reference list of matching values.
module tb_div_flag_enumerator;

  localparam int WIDTH = 4;
  localparam int NV    = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             want_even;
  logic             want_div3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   match_cnt;
  logic             chk_even;
  logic             chk_div3;

  int tests;
  int fails;
  int seen_cnt [0:NV];

  div_flag_enumerator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .want_even (want_even),
    .want_div3 (want_div3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
  );

  div_flags #(.WIDTH(WIDTH)) u_chk (
    .value_i (out_value),
    .even_o  (chk_even),
    .div3_o  (chk_div3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full scan: start, consume the stream under the chosen ready policy,
  // then confirm the done pulse and the return to IDLE.
  // mode 0: ready high, 1: random ready, 2: hold ready low 5 cycles on first value.
  task automatic run_scan(input bit we, input bit wd, input int mode, input bit noise);
    int         exp_q[$];
    int         idx;
    int         stalls;
    int         stall_run;
    int         first_k;
    bit         done_seen;
    bit         r;
    logic       prev_valid;
    logic       prev_ready;
    logic [WIDTH-1:0] prev_value;

    exp_q = {};
    for (int v = 1; v <= NV; v++) begin
      if ((((v % 2) == 0) == we) && (((v % 3) == 0) == wd)) exp_q.push_back(v);
    end

    @(negedge clk);
    want_even = we;
    want_div3 = wd;
    out_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cnt_cleared", match_cnt, 0);

    idx = 0; stalls = 0; stall_run = 0; first_k = -1;
    done_seen = 0; prev_valid = 0; prev_ready = 0; prev_value = '0;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      if (k > 0) @(negedge clk);
      if (prev_valid && !prev_ready) begin
        check("valid_hold", out_valid, 1);
        check("value_hold", out_value, prev_value);
      end
      if (done) begin
        done_seen = 1;
        check("done_cycle", k, NV + exp_q.size() + stalls);
        check("match_cnt_end", match_cnt, exp_q.size());
        check("emitted_count", idx, exp_q.size());
        check("busy_in_done", busy, 0);
        start = noise ? 1'b1 : 1'b0;
      end else begin
        r = 1'b1;
        if (out_valid) begin
          if (first_k < 0) begin
            first_k = k;
            if (exp_q.size() > 0) check("first_valid_edge", k, exp_q[0]);
          end
          if (!(prev_valid && !prev_ready)) begin
            if (idx < exp_q.size()) check("out_value", out_value, exp_q[idx]);
            else check("extra_value", 1, 0);
            check("flags_even", chk_even, we);
            check("flags_div3", chk_div3, wd);
            check("match_cnt_run", match_cnt, idx + 1);
            seen_cnt[out_value]++;
          end
          case (mode)
            1:       r = 1'($urandom_range(0, 1));
            2:       r = !(idx == 0 && stall_run < 5);
            default: r = 1'b1;
          endcase
          if (!r) begin
            stalls++;
            stall_run++;
          end else begin
            idx++;
          end
        end else begin
          r = 1'($urandom_range(0, 1));
        end
        out_ready  = r;
        prev_valid = out_valid;
        prev_ready = r;
        prev_value = out_value;
        if (noise) begin
          start     = 1'($urandom_range(0, 1));
          want_even = 1'($urandom_range(0, 1));
          want_div3 = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);

    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("match_cnt_held", match_cnt, exp_q.size());
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    int  waited;
    bit  we;
    bit  wd;
    tests = 0;
    fails = 0;
    for (int v = 0; v <= NV; v++) seen_cnt[v] = 0;
    rst = 1'b1; start = 1'b0; want_even = 1'b0; want_div3 = 1'b0; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_value", out_value, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", match_cnt, 0);
    rst = 1'b0;
    $display("[TB] reset released");

    run_scan(1'b1, 1'b0, 0, 1'b0);
    $display("[TB] scan want=(1,0) ready high");
    run_scan(1'b1, 1'b1, 2, 1'b0);
    $display("[TB] scan want=(1,1) 5-cycle stall on first value");
    run_scan(1'b0, 1'b1, 0, 1'b1);
    $display("[TB] scan want=(0,1) with start/want noise");
    run_scan(1'b0, 1'b0, 1, 1'b0);
    $display("[TB] scan want=(0,0) random ready");

    check("zero_never_emitted", seen_cnt[0], 0);
    for (int v = 1; v <= NV; v++) check($sformatf("union_%0d", v), seen_cnt[v], 1);

    for (int i = 0; i < 4; i++) begin
      we = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      run_scan(we, wd, 1, 1'($urandom_range(0, 1)));
      $display("[TB] random scan want=(%0d,%0d)", we, wd);
    end

    @(negedge clk);
    want_even = 1'b1; want_div3 = 1'b1; out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_value", out_value, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_cnt", match_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset during EMIT");
    run_scan(1'b1, 1'b1, 0, 1'b0);
    $display("[TB] scan want=(1,1) after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
